// File: rtl/if_prefetch_stage.sv
// Instruction fetch prefetch stage: issues word-aligned fetches, tracks in-flight
// requests, buffers returned instructions with their PCs and presents them to Decode.
module if_prefetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_ip,
  input  logic [XLEN-1:0] redirect_pc_ip,
  output logic            instr_req_op,
  output logic [XLEN-1:0] instr_addr_op,
  input  logic            instr_gnt_ip,
  input  logic            instr_rvalid_ip,
  input  logic [XLEN-1:0] instr_rdata_ip,
  output logic            instr_valid_op,
  output logic [XLEN-1:0] instr_data_op,
  output logic [XLEN-1:0] instr_pc_op,
  input  logic            instr_ready_ip
);

  localparam int unsigned     PTR_W      = $clog2(DEPTH);
  localparam int unsigned     CNT_W      = $clog2(DEPTH + 1);
  // Stale responses can pile up across back-to-back redirects, so discard gets headroom.
  localparam int unsigned     DSC_W      = CNT_W + 4;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  q_data  [DEPTH];
  logic [XLEN-1:0]  q_pc    [DEPTH];
  logic [XLEN-1:0]  pc_fifo [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] pf_rd_ptr;
  logic [PTR_W-1:0] pf_wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic [DSC_W-1:0] discard;
  logic [DSC_W-1:0] discard_redirect;
  logic [CNT_W:0]   occupancy;
  logic             grant;
  logic             keep;
  logic             pop;

  // Every outstanding request has a reserved queue slot, so the queue cannot overflow.
  always_comb begin
    occupancy    = {1'b0, count} + {1'b0, outstanding};
    instr_req_op = !reset && !redirect_ip && (occupancy < (CNT_W + 1)'(DEPTH));
    instr_addr_op = fetch_pc;
    grant        = instr_req_op && instr_gnt_ip;
    keep         = instr_rvalid_ip && (discard == '0);
    pop          = (count != '0) && instr_ready_ip;
  end

  always_comb begin
    instr_valid_op = (count != '0);
    instr_data_op  = instr_valid_op ? q_data[rd_ptr] : '0;
    instr_pc_op    = instr_valid_op ? q_pc[rd_ptr]   : '0;
  end

  // Redirect turns all live requests into stale ones; a response landing now retires one.
  always_comb begin
    discard_redirect = discard + DSC_W'(outstanding);
    if (instr_rvalid_ip && (discard_redirect != '0)) begin
      discard_redirect = discard_redirect - DSC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC & ALIGN_MASK;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pf_rd_ptr   <= '0;
      pf_wr_ptr   <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_ip) begin
      fetch_pc    <= redirect_pc_ip & ALIGN_MASK;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pf_rd_ptr   <= '0;
      pf_wr_ptr   <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= discard_redirect;
    end else begin
      if (grant) begin
        fetch_pc           <= fetch_pc + XLEN'(4);
        pc_fifo[pf_wr_ptr] <= fetch_pc;
        pf_wr_ptr          <= pf_wr_ptr + PTR_W'(1);
      end
      if (instr_rvalid_ip && !keep) begin
        discard <= discard - DSC_W'(1);
      end
      if (keep) begin
        q_data[wr_ptr] <= instr_rdata_ip;
        q_pc[wr_ptr]   <= pc_fifo[pf_rd_ptr];
        wr_ptr         <= wr_ptr + PTR_W'(1);
        pf_rd_ptr      <= pf_rd_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count       <= count + CNT_W'(keep) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(keep);
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: in-order memory responder plus a queue-level
// model of fetched/delivered instructions checked every cycle.
module tb_if_prefetch_stage;

  localparam int unsigned XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        redirect_ip;
  logic [31:0] redirect_pc_ip;
  logic        instr_req_op;
  logic [31:0] instr_addr_op;
  logic        instr_gnt_ip;
  logic        instr_rvalid_ip;
  logic [31:0] instr_rdata_ip;
  logic        instr_valid_op;
  logic [31:0] instr_data_op;
  logic [31:0] instr_pc_op;
  logic        instr_ready_ip;

  if_prefetch_stage #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_ip     (redirect_ip),
    .redirect_pc_ip  (redirect_pc_ip),
    .instr_req_op    (instr_req_op),
    .instr_addr_op   (instr_addr_op),
    .instr_gnt_ip    (instr_gnt_ip),
    .instr_rvalid_ip (instr_rvalid_ip),
    .instr_rdata_ip  (instr_rdata_ip),
    .instr_valid_op  (instr_valid_op),
    .instr_data_op   (instr_data_op),
    .instr_pc_op     (instr_pc_op),
    .instr_ready_ip  (instr_ready_ip)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int n_grants = 0;

  logic        s_reset    = 1'b1;
  logic        s_redirect = 1'b0;
  logic [31:0] s_rpc      = '0;
  logic        s_gnt      = 1'b0;
  logic        s_resp     = 1'b0;
  logic        s_ready    = 1'b0;

  logic [31:0] pend[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_data[$];

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  ent_t        m_q[$];
  fl_t         m_fl[$];
  logic [31:0] m_fetch = '0;
  bit          m_init  = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, let the memory observe just before the rising edge.
  task automatic cycle();
    @(negedge clock);
    reset           = s_reset;
    redirect_ip     = s_redirect;
    redirect_pc_ip  = s_rpc;
    instr_gnt_ip    = s_gnt;
    instr_ready_ip  = s_ready;
    instr_rvalid_ip = s_resp && (pend.size() > 0);
    instr_rdata_ip  = instr_rvalid_ip ? mem_word(pend[0]) : '0;
    #4;
    if (instr_rvalid_ip) void'(pend.pop_front());
    if (instr_req_op && instr_gnt_ip) begin
      pend.push_back(instr_addr_op);
      n_grants++;
    end
    if (reset) pend.delete();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Model: fetch address, in-flight list (stale after redirect), delivered queue.
  always @(negedge clock) begin : compare
    int   live;
    logic exp_req;
    fl_t  f;
    #4;
    live = 0;
    foreach (m_fl[i]) if (!m_fl[i].stale) live++;
    exp_req = !reset && !redirect_ip && ((m_q.size() + live) < DEPTH);
    if (m_init) begin
      chk("req", instr_req_op, exp_req);
      if (exp_req) chk("addr", instr_addr_op, m_fetch);
      chk("valid", instr_valid_op, m_q.size() > 0);
      chk("head_pc", instr_pc_op, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
      chk("head_data", instr_data_op, (m_q.size() > 0) ? m_q[0].data : 32'h0);
      if (instr_valid_op && instr_ready_ip && !reset && !redirect_ip) begin
        dlv_pc.push_back(instr_pc_op);
        dlv_data.push_back(instr_data_op);
      end
    end
    if (reset) begin
      m_fetch = RPC & ~32'h3;
      m_q.delete();
      m_fl.delete();
      m_init = 1'b1;
    end else if (redirect_ip) begin
      if (instr_rvalid_ip && m_fl.size() > 0) void'(m_fl.pop_front());
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      m_q.delete();
      m_fetch = redirect_pc_ip & ~32'h3;
    end else begin
      if (instr_ready_ip && m_q.size() > 0) void'(m_q.pop_front());
      if (instr_rvalid_ip && m_fl.size() > 0) begin
        f = m_fl.pop_front();
        if (!f.stale) m_q.push_back('{pc: f.pc, data: instr_rdata_ip});
      end
      if (exp_req && instr_gnt_ip) begin
        m_fl.push_back('{pc: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; redirect_ip = 1'b0; redirect_pc_ip = '0; instr_gnt_ip = 1'b0;
    instr_rvalid_ip = 1'b0; instr_rdata_ip = '0; instr_ready_ip = 1'b0;

    // Reset values
    run(3);
    chk("rst_req", instr_req_op, 0);
    chk("rst_valid", instr_valid_op, 0);
    chk("rst_pc", instr_pc_op, 0);
    chk("rst_data", instr_data_op, 0);

    // Streaming: grant every cycle, response one cycle later
    dlv_pc.delete(); dlv_data.delete();
    s_reset = 1'b0; s_gnt = 1'b1; s_resp = 1'b1; s_ready = 1'b1;
    cycle();
    chk("first_req", instr_req_op, 1);
    chk("first_addr", instr_addr_op, RPC);
    cycle();
    chk("lat_valid_early", instr_valid_op, 0);
    cycle();
    chk("lat_valid", instr_valid_op, 1);
    chk("lat_pc", instr_pc_op, 32'h0);
    chk("lat_data", instr_data_op, mem_word(32'h0));
    run(16);
    chk("stream_len_ok", dlv_pc.size() >= 8, 1);
    if (dlv_pc.size() >= 8)
      for (int i = 0; i < 8; i++) begin
        chk("stream_pc", dlv_pc[i], 32'(i * 4));
        chk("stream_data", dlv_data[i], mem_word(32'(i * 4)));
      end

    // Decode stall fills the queue, then drains in order
    s_reset = 1'b1; run(2);
    dlv_pc.delete(); dlv_data.delete();
    s_reset = 1'b0; s_ready = 1'b0; s_gnt = 1'b1; s_resp = 1'b1;
    n_grants = 0;
    run(10);
    chk("stall_grants", n_grants, 4);
    chk("stall_req", instr_req_op, 0);
    chk("stall_valid", instr_valid_op, 1);
    chk("stall_head_pc", instr_pc_op, 32'h0);
    s_ready = 1'b1;
    run(10);
    chk("drain_len_ok", dlv_pc.size() >= 5, 1);
    if (dlv_pc.size() >= 5)
      for (int i = 0; i < 5; i++) chk("drain_pc", dlv_pc[i], 32'(i * 4));

    // Redirect with 3 outstanding
    s_reset = 1'b1; run(2);
    s_reset = 1'b0; s_gnt = 1'b1; s_resp = 1'b0; s_ready = 1'b1;
    n_grants = 0;
    run(3);
    chk("pre_redirect_grants", n_grants, 3);
    s_redirect = 1'b1; s_rpc = 32'h0000_0103;
    cycle();
    chk("redirect_req", instr_req_op, 0);
    s_redirect = 1'b0; s_gnt = 1'b0;
    cycle();
    chk("redir_req", instr_req_op, 1);
    chk("redir_addr", instr_addr_op, 32'h0000_0100);
    chk("redir_valid", instr_valid_op, 0);
    dlv_pc.delete(); dlv_data.delete();
    s_gnt = 1'b1; s_resp = 1'b1;
    run(12);
    chk("redir_len_ok", dlv_pc.size() >= 3, 1);
    if (dlv_pc.size() >= 3) begin
      chk("redir_pc0", dlv_pc[0], 32'h0000_0100);
      chk("redir_pc1", dlv_pc[1], 32'h0000_0104);
      chk("redir_pc2", dlv_pc[2], 32'h0000_0108);
      chk("redir_data0", dlv_data[0], mem_word(32'h0000_0100));
    end

    // Redirect with a response landing in the same cycle
    s_redirect = 1'b1; s_rpc = 32'h0000_2000;
    cycle();
    dlv_pc.delete(); dlv_data.delete();
    s_redirect = 1'b0;
    cycle();
    chk("redir2_valid", instr_valid_op, 0);
    chk("redir2_addr", instr_addr_op, 32'h0000_2000);
    run(12);
    chk("redir2_len_ok", dlv_pc.size() >= 1, 1);
    if (dlv_pc.size() >= 1) chk("redir2_pc0", dlv_pc[0], 32'h0000_2000);

    // Fetch address wrap at the top of the address space
    s_redirect = 1'b1; s_rpc = 32'hFFFF_FFFE;
    cycle();
    dlv_pc.delete(); dlv_data.delete();
    s_redirect = 1'b0;
    cycle();
    chk("wrap_addr_top", instr_addr_op, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr_zero", instr_addr_op, 32'h0000_0000);
    run(12);
    chk("wrap_len_ok", dlv_pc.size() >= 2, 1);
    if (dlv_pc.size() >= 2) begin
      chk("wrap_pc0", dlv_pc[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", dlv_pc[1], 32'h0000_0000);
    end

    // Reset mid-operation, dominating redirect/grant/response
    s_reset = 1'b1; run(2);
    s_reset = 1'b0; s_ready = 1'b0; s_gnt = 1'b1; s_resp = 1'b0;
    run(4);
    s_gnt = 1'b0; s_resp = 1'b1;
    run(2);
    chk("mid_valid", instr_valid_op, 1);
    chk("mid_pc", instr_pc_op, 32'h0);
    s_reset = 1'b1; s_redirect = 1'b1; s_rpc = 32'h0000_0500;
    s_gnt = 1'b1; s_resp = 1'b1; s_ready = 1'b1;
    cycle();
    chk("mid_rst_req", instr_req_op, 0);
    s_redirect = 1'b0;
    cycle();
    chk("mid_rst_valid", instr_valid_op, 0);
    chk("mid_rst_pc", instr_pc_op, 0);
    chk("mid_rst_data", instr_data_op, 0);
    s_reset = 1'b0;
    cycle();
    chk("mid_rst_req_after", instr_req_op, 1);
    chk("mid_rst_addr_after", instr_addr_op, RPC);
    run(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
